// File: rtl/spi_slave_duplex.sv
// spi_slave_duplex: SPI mode-0 full-duplex responder.
// Oversamples sclk/ss/mosi in the clk domain, shifts a preloaded word out on
// miso MSB first while capturing mosi into rx_data.
// Optional feature macro: SPI_SLAVE_RX_HANDSHAKE_EN (adds rx_ready/rx_overrun
// and turns rx_valid into a level held until consumed).
module spi_slave_duplex #(
  parameter int unsigned           DATA_WIDTH  = 8,
  parameter int unsigned           SYNC_STAGES = 2,
  parameter logic [DATA_WIDTH-1:0] TX_DEFAULT  = '0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  sclk,
  input  logic                  ss,
  input  logic                  mosi,
  output logic                  miso,
  input  logic [DATA_WIDTH-1:0] tx_data,
  input  logic                  tx_valid,
  output logic                  tx_ready,
  output logic [DATA_WIDTH-1:0] rx_data,
  output logic                  rx_valid,
`ifdef SPI_SLAVE_RX_HANDSHAKE_EN
  input  logic                  rx_ready,
  output logic                  rx_overrun,
`endif
  output logic                  busy,
  output logic                  frame_err
);

  localparam int unsigned   CW      = $clog2(DATA_WIDTH + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(DATA_WIDTH);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACTIVE,
    ST_DONE
  } state_e;

  state_e                  state_q, state_d;
  logic [SYNC_STAGES-1:0]  sclk_sync_q, sclk_sync_d;
  logic [SYNC_STAGES-1:0]  ss_sync_q, ss_sync_d;
  logic [SYNC_STAGES-1:0]  mosi_sync_q, mosi_sync_d;
  logic                    sclk_hist_q, sclk_hist_d;
  logic                    ss_hist_q, ss_hist_d;
  logic [CW-1:0]           bit_cnt_q, bit_cnt_d;
  logic [DATA_WIDTH-1:0]   shift_tx_q, shift_tx_d;
  logic [DATA_WIDTH-2:0]   shift_rx_q, shift_rx_d;
  logic                    miso_q, miso_d;
  logic [DATA_WIDTH-1:0]   txbuf_q, txbuf_d;
  logic                    txbuf_full_q, txbuf_full_d;
  logic [DATA_WIDTH-1:0]   rx_data_q, rx_data_d;
  logic                    rx_valid_q, rx_valid_d;
  logic                    frame_err_q, frame_err_d;
`ifdef SPI_SLAVE_RX_HANDSHAKE_EN
  logic                    rx_overrun_q, rx_overrun_d;
`endif

  logic                    sclk_s, ss_s, mosi_s;
  logic                    sclk_rise, sclk_fall, ss_rise, ss_fall;
  logic                    rise_take, complete, abort, start, tx_accept;
  logic [CW-1:0]           cnt_next;
  logic [DATA_WIDTH-1:0]   rx_word;
  logic [DATA_WIDTH-1:0]   tx_load;

  // Synchronizer chains and edge detection against a history flop
  always_comb begin
    sclk_sync_d = {sclk_sync_q[SYNC_STAGES-2:0], sclk};
    ss_sync_d   = {ss_sync_q[SYNC_STAGES-2:0], ss};
    mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], mosi};
    sclk_s      = sclk_sync_q[SYNC_STAGES-1];
    ss_s        = ss_sync_q[SYNC_STAGES-1];
    mosi_s      = mosi_sync_q[SYNC_STAGES-1];
    sclk_hist_d = sclk_s;
    ss_hist_d   = ss_s;
    sclk_rise   = sclk_s & ~sclk_hist_q;
    sclk_fall   = ~sclk_s & sclk_hist_q;
    ss_rise     = ss_s & ~ss_hist_q;
    ss_fall     = ~ss_s & ss_hist_q;
  end

  // Frame events shared by next-state and datapath logic
  always_comb begin
    rise_take = (state_q == ST_ACTIVE) && sclk_rise && (bit_cnt_q < CNT_MAX);
    cnt_next  = rise_take ? (bit_cnt_q + CW'(1)) : bit_cnt_q;
    // A final sclk rise landing with ss rise still completes the frame
    complete  = rise_take && (cnt_next == CNT_MAX);
    abort     = (state_q == ST_ACTIVE) && ss_rise && !complete;
    start     = (state_q == ST_IDLE) && ss_fall;
    tx_accept = tx_valid && !txbuf_full_q;
    rx_word   = {shift_rx_q, mosi_s};
    // A write arriving in the start cycle bypasses the buffer into this frame
    if (txbuf_full_q) begin
      tx_load = txbuf_q;
    end else if (tx_accept) begin
      tx_load = tx_data;
    end else begin
      tx_load = TX_DEFAULT;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (ss_fall) begin
          state_d = ST_ACTIVE;
        end
      end
      ST_ACTIVE: begin
        if (complete) begin
          state_d = ss_rise ? ST_IDLE : ST_DONE;
        end else if (ss_rise) begin
          state_d = ST_IDLE;
        end
      end
      ST_DONE: begin
        if (ss_rise) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Datapath and registered outputs
  always_comb begin
    bit_cnt_d    = bit_cnt_q;
    shift_tx_d   = shift_tx_q;
    shift_rx_d   = shift_rx_q;
    miso_d       = miso_q;
    txbuf_d      = txbuf_q;
    txbuf_full_d = txbuf_full_q;
    rx_data_d    = rx_data_q;
    frame_err_d  = 1'b0;
`ifdef SPI_SLAVE_RX_HANDSHAKE_EN
    rx_valid_d   = rx_valid_q & ~rx_ready;
    rx_overrun_d = 1'b0;
`else
    rx_valid_d   = 1'b0;
`endif

    if (start) begin
      txbuf_full_d = 1'b0;
    end else if (tx_accept) begin
      txbuf_d      = tx_data;
      txbuf_full_d = 1'b1;
    end

    case (state_q)
      ST_IDLE: begin
        miso_d    = 1'b0;
        bit_cnt_d = '0;
        if (start) begin
          shift_tx_d = tx_load;
          shift_rx_d = '0;
          miso_d     = tx_load[DATA_WIDTH-1];
        end
      end
      ST_ACTIVE: begin
        bit_cnt_d = cnt_next;
        if (rise_take) begin
          shift_rx_d = rx_word[DATA_WIDTH-2:0];
        end
        if (sclk_fall && (bit_cnt_q < CNT_MAX)) begin
          shift_tx_d = shift_tx_q << 1;
          miso_d     = shift_tx_q[DATA_WIDTH-2];
        end
        if (complete) begin
          rx_data_d  = rx_word;
          rx_valid_d = 1'b1;
          miso_d     = 1'b0;
`ifdef SPI_SLAVE_RX_HANDSHAKE_EN
          rx_overrun_d = rx_valid_q & ~rx_ready;
`endif
          if (ss_rise) begin
            bit_cnt_d = '0;
          end
        end else if (abort) begin
          frame_err_d = (cnt_next != '0);
          miso_d      = 1'b0;
          bit_cnt_d   = '0;
        end
      end
      ST_DONE: begin
        miso_d = 1'b0;
        if (ss_rise) begin
          bit_cnt_d = '0;
        end
      end
      default: begin
        miso_d    = 1'b0;
        bit_cnt_d = '0;
      end
    endcase
  end

  // Output decode
  always_comb begin
    miso      = miso_q;
    tx_ready  = ~txbuf_full_q;
    rx_data   = rx_data_q;
    rx_valid  = rx_valid_q;
    busy      = (state_q != ST_IDLE);
    frame_err = frame_err_q;
`ifdef SPI_SLAVE_RX_HANDSHAKE_EN
    rx_overrun = rx_overrun_q;
`endif
  end

  // State register with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      sclk_sync_q  <= '0;
      ss_sync_q    <= '1;
      mosi_sync_q  <= '0;
      sclk_hist_q  <= 1'b0;
      ss_hist_q    <= 1'b1;
      bit_cnt_q    <= '0;
      shift_tx_q   <= '0;
      shift_rx_q   <= '0;
      miso_q       <= 1'b0;
      txbuf_q      <= '0;
      txbuf_full_q <= 1'b0;
      rx_data_q    <= '0;
      rx_valid_q   <= 1'b0;
      frame_err_q  <= 1'b0;
`ifdef SPI_SLAVE_RX_HANDSHAKE_EN
      rx_overrun_q <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      sclk_sync_q  <= sclk_sync_d;
      ss_sync_q    <= ss_sync_d;
      mosi_sync_q  <= mosi_sync_d;
      sclk_hist_q  <= sclk_hist_d;
      ss_hist_q    <= ss_hist_d;
      bit_cnt_q    <= bit_cnt_d;
      shift_tx_q   <= shift_tx_d;
      shift_rx_q   <= shift_rx_d;
      miso_q       <= miso_d;
      txbuf_q      <= txbuf_d;
      txbuf_full_q <= txbuf_full_d;
      rx_data_q    <= rx_data_d;
      rx_valid_q   <= rx_valid_d;
      frame_err_q  <= frame_err_d;
`ifdef SPI_SLAVE_RX_HANDSHAKE_EN
      rx_overrun_q <= rx_overrun_d;
`endif
    end
  end

endmodule

// File: tb/tb_spi_slave_duplex.sv
// Bench for spi_slave_duplex: directed vector table, reset/corner sequences,
// and randomized frames checked against a frame-level reference model.
module tb_spi_slave_duplex;

  localparam int HALF = 8;   // sclk half-period in clk cycles
  localparam int SYNC = 2;   // matches the DUT default SYNC_STAGES

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       sclk = 1'b0;
  logic       ss = 1'b1;
  logic       mosi = 1'b0;
  logic       miso;
  logic [7:0] tx_data = '0;
  logic       tx_valid = 1'b0;
  logic       tx_ready;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       busy;
  logic       frame_err;
`ifdef SPI_SLAVE_RX_HANDSHAKE_EN
  logic       rx_ready = 1'b1;
  logic       rx_overrun;
`endif

  spi_slave_duplex #(
    .DATA_WIDTH (8),
    .SYNC_STAGES(SYNC),
    .TX_DEFAULT (8'h00)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .sclk     (sclk),
    .ss       (ss),
    .mosi     (mosi),
    .miso     (miso),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
`ifdef SPI_SLAVE_RX_HANDSHAKE_EN
    .rx_ready (rx_ready),
    .rx_overrun(rx_overrun),
`endif
    .busy     (busy),
    .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  int   n_cmp = 0;
  int   n_bad = 0;
  int   rxv_cycles = 0;
  int   ferr_cnt = 0;
  int   txr_falls = 0;
  int   ovr_cnt = 0;
  logic prev_txr = 1'b1;

  // Event counters sampled on the falling clk edge
  always @(negedge clk) begin
    if (rx_valid) rxv_cycles++;
    if (frame_err) ferr_cnt++;
    if (prev_txr && !tx_ready) txr_falls++;
    prev_txr = tx_ready;
`ifdef SPI_SLAVE_RX_HANDSHAKE_EN
    if (rx_overrun) ovr_cnt++;
`endif
  end

  typedef struct {
    bit       load;     // preload tx buffer before the frame
    bit       sw;       // write tx word in the exact frame-start cycle
    bit [7:0] tx;
    bit [7:0] mosi_w;
    int       nbits;
    bit [7:0] exp_miso; // top nbits of the word seen by the master
    int       exp_rxv;
    int       exp_err;
    int       exp_falls;
    bit [7:0] exp_rx;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic load_tx(input logic [7:0] w);
    int t;
    t = 0;
    @(negedge clk);
    while (!tx_ready && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (!tx_ready) check("tx_ready_wait", tx_ready, 1);
    tx_data  = w;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
    check("tx_ready_after_load", tx_ready, 0);
  endtask

  task automatic spi_frame(input logic [7:0] mw, input int nbits, input bit sw,
                           input logic [7:0] sw_word, output logic [7:0] got);
    got = '0;
    @(negedge clk);
    ss   = 1'b0;
    mosi = mw[7];
    if (sw) begin
      repeat (SYNC) @(posedge clk);
      @(negedge clk);
      tx_data  = sw_word;
      tx_valid = 1'b1;
      @(negedge clk);
      tx_valid = 1'b0;
    end
    repeat (HALF) @(negedge clk);
    for (int i = 0; i < nbits; i++) begin
      got  = {got[6:0], miso};
      sclk = 1'b1;
      repeat (HALF) @(negedge clk);
      sclk = 1'b0;
      if (i < 7) mosi = mw[6-i];
      repeat (HALF) @(negedge clk);
    end
    ss   = 1'b1;
    mosi = 1'b0;
    repeat (2 * HALF) @(negedge clk);
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    int r0, e0, f0;
    logic [7:0] got;
    r0 = rxv_cycles;
    e0 = ferr_cnt;
    f0 = txr_falls;
    if (v.load) load_tx(v.tx);
    spi_frame(v.mosi_w, v.nbits, v.sw, v.tx, got);
    check({tag, "_miso_word"}, got, v.exp_miso);
    check({tag, "_rx_valid_cycles"}, rxv_cycles - r0, v.exp_rxv);
    check({tag, "_frame_err_pulses"}, ferr_cnt - e0, v.exp_err);
    check({tag, "_tx_ready_falls"}, txr_falls - f0, v.exp_falls);
    check({tag, "_rx_data"}, rx_data, v.exp_rx);
    check({tag, "_tx_ready_idle"}, tx_ready, 1);
    check({tag, "_busy_idle"}, busy, 0);
  endtask

  vec_t       vecs[7];
  vec_t       rv;
  logic [7:0] model_rx;
  logic [7:0] got;
  int         r0, e0;

  initial begin
    //       load sw  tx     mosi   nb miso   rxv err falls rx
    vecs[0] = '{1, 0, 8'hA5, 8'h3C, 8, 8'hA5, 1, 0, 1, 8'h3C};
    vecs[1] = '{0, 0, 8'h00, 8'hFF, 8, 8'h00, 1, 0, 0, 8'hFF};
    vecs[2] = '{1, 0, 8'hC3, 8'hE7, 3, 8'h06, 0, 1, 1, 8'hFF};
    vecs[3] = '{0, 0, 8'h00, 8'h81, 8, 8'h00, 1, 0, 0, 8'h81};
    vecs[4] = '{1, 0, 8'h10, 8'h01, 8, 8'h10, 1, 0, 1, 8'h01};
    vecs[5] = '{1, 0, 8'h20, 8'h02, 8, 8'h20, 1, 0, 1, 8'h02};
    vecs[6] = '{0, 1, 8'h6E, 8'h99, 8, 8'h6E, 1, 0, 0, 8'h99};

    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_miso", miso, 0);
    check("rst_tx_ready", tx_ready, 1);
    check("rst_rx_data", rx_data, 0);
    check("rst_rx_valid", rx_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_frame_err", frame_err, 0);
`ifdef SPI_SLAVE_RX_HANDSHAKE_EN
    check("rst_rx_overrun", rx_overrun, 0);
`endif

    for (int k = 0; k < 7; k++) run_vec(vecs[k], $sformatf("vec%0d", k));

    // Reset pulse in the middle of a frame, after four sclk rises
    load_tx(8'h3F);
    r0 = rxv_cycles;
    e0 = ferr_cnt;
    @(negedge clk);
    ss = 1'b0;
    mosi = 1'b1;
    repeat (HALF) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      sclk = 1'b1;
      repeat (HALF) @(negedge clk);
      sclk = 1'b0;
      repeat (HALF) @(negedge clk);
    end
    check("midframe_busy", busy, 1);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("midrst_miso", miso, 0);
    check("midrst_tx_ready", tx_ready, 1);
    check("midrst_rx_data", rx_data, 0);
    check("midrst_rx_valid", rx_valid, 0);
    check("midrst_busy", busy, 0);
    check("midrst_frame_err", frame_err, 0);
    repeat (HALF) @(negedge clk);
    ss = 1'b1;
    mosi = 1'b0;
    repeat (2 * HALF) @(negedge clk);
    check("midrst_no_err", ferr_cnt - e0, 0);
    check("midrst_no_rx", rxv_cycles - r0, 0);
    rv = '{0, 0, 8'h00, 8'h5A, 8, 8'h00, 1, 0, 0, 8'h5A};
    run_vec(rv, "after_rst");
    model_rx = 8'h5A;

`ifdef SPI_SLAVE_RX_HANDSHAKE_EN
    rx_ready = 1'b0;
    r0 = ovr_cnt;
    spi_frame(8'h11, 8, 1'b0, 8'h00, got);
    check("hs_first_valid_held", rx_valid, 1);
    spi_frame(8'h22, 8, 1'b0, 8'h00, got);
    check("hs_overrun_pulses", ovr_cnt - r0, 1);
    check("hs_rx_data", rx_data, 8'h22);
    check("hs_valid_held", rx_valid, 1);
    rx_ready = 1'b1;
    @(negedge clk);
    check("hs_valid_dropped", rx_valid, 0);
    model_rx = 8'h22;
`endif

    // Randomized frames against a frame-level model
    for (int k = 0; k < 40; k++) begin
      int sel;
      rv.load   = $urandom_range(0, 1);
      rv.sw     = 1'b0;
      rv.tx     = 8'($urandom);
      rv.mosi_w = 8'($urandom);
      sel       = $urandom_range(0, 5);
      rv.nbits  = (sel < 4) ? 8 : (sel == 4) ? $urandom_range(1, 7) : 0;
      begin
        logic [7:0] src;
        src = rv.load ? rv.tx : 8'h00;
        rv.exp_miso = (rv.nbits == 0) ? 8'h00 : 8'(src >> (8 - rv.nbits));
      end
      rv.exp_rxv   = (rv.nbits == 8) ? 1 : 0;
      rv.exp_err   = (rv.nbits > 0 && rv.nbits < 8) ? 1 : 0;
      rv.exp_falls = rv.load ? 1 : 0;
      if (rv.nbits == 8) model_rx = rv.mosi_w;
      rv.exp_rx = model_rx;
      run_vec(rv, $sformatf("rand%0d", k));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
